// File: rtl/sync_w2r_multi.sv
// sync_w2r_multi
// Read-domain synchroniser for CHANNELS Gray-coded write pointers. Each
// channel passes through a SYNC_STAGES-deep flop chain. It then gets a
// registered Gray-to-binary conversion, a one-cycle change strobe and a
// sticky flag for any step that is not Gray-adjacent.
module sync_w2r_multi #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CHANNELS    = 1
) (
    input  logic                                rclk,
    input  logic                                rrst_n,
    input  logic [CHANNELS*(ADDRSIZE+1)-1:0]    wptr,
    input  logic [CHANNELS-1:0]                 err_clr,
    output logic [CHANNELS*(ADDRSIZE+1)-1:0]    rq_wptr,
    output logic [CHANNELS*(ADDRSIZE+1)-1:0]    rq_wbin,
    output logic [CHANNELS-1:0]                 rq_chg,
    output logic [CHANNELS-1:0]                 gray_err
);

    localparam int W  = ADDRSIZE + 1;
    localparam int CW = SYNC_STAGES * W;

    // Reject configurations outside the supported range at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sync_w2r_multi: SYNC_STAGES must be 2..4");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("sync_w2r_multi: CHANNELS must be 1..8");
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit differs, which is an illegal Gray step.
    function automatic logic multi_bit(input logic [W-1:0] d);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + {7'd0, d[i]};
        end
        return (cnt > 8'd1);
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CW-1:0] chain_q, chain_d;
        logic [W-1:0]  prev_q, prev_d;
        logic [W-1:0]  wbin_q, wbin_d;
        logic          chg_q, chg_d;
        logic          err_q, err_d;
        logic [W-1:0]  last_s;
        logic          viol_s;

        // The last stage of the chain is the synchronised pointer.
        assign last_s = chain_q[CW-1 -: W];

        // Next-state logic: shift the chain and compare against the previous value.
        always_comb begin
            chain_d = {chain_q[CW-W-1:0], wptr[c*W +: W]};
            prev_d  = last_s;
            wbin_d  = gray2bin(last_s);
            chg_d   = (last_s != prev_q);
            viol_s  = multi_bit(last_s ^ prev_q);
            if (viol_s) begin
                err_d = 1'b1;
            end else if (err_clr[c]) begin
                err_d = 1'b0;
            end else begin
                err_d = err_q;
            end
        end

        // Channel state registers; asynchronous reset clears everything.
        always_ff @(posedge rclk or negedge rrst_n) begin
            if (!rrst_n) begin
                chain_q <= {CW{1'b0}};
                prev_q  <= {W{1'b0}};
                wbin_q  <= {W{1'b0}};
                chg_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                chain_q <= chain_d;
                prev_q  <= prev_d;
                wbin_q  <= wbin_d;
                chg_q   <= chg_d;
                err_q   <= err_d;
            end
        end

        assign rq_wptr[c*W +: W] = last_s;
        assign rq_wbin[c*W +: W] = wbin_q;
        assign rq_chg[c]         = chg_q;
        assign gray_err[c]       = err_q;
    end

endmodule
